idft8_wb_top: RTL and testbench
===============================

// Module: idft8_wb_top
// PURPOSE
//  8-point complex inverse DFT accelerator behind a Wishbone classic slave port.
//  Host writes X[k] (real/imag, 32-bit signed), pulses START, polls DONE, then
//  reads x[n] = (1/8)*sum_k X[k]*exp(+j*2*pi*k*n/8). Standalone memory-mapped peripheral.
// PARAMETERS
//  DATA_W   32  width of samples, DAT_I/DAT_O
//  TW_FRAC  14  fractional bits of twiddle constants (Q1.14, 16-bit signed)
//  ADR_W     8  Wishbone address width
// PORTS
//  CLK_I  in   1       system clock, all logic on rising edge
//  RST_I  in   1       synchronous reset, active-low
//  CYC_I  in   1       bus cycle valid
//  STB_I  in   1       strobe
//  WE_I   in   1       1=write, 0=read
//  ADR_I  in   ADR_W   register address
//  DAT_I  in   DATA_W  write data
//  DAT_O  out  DATA_W  read data, valid while ACK_O=1
//  ACK_O  out  1       transfer acknowledge
// BEHAVIOUR
//  Reset (RST_I=0 at edge): all X/x registers, DAT_O, ACK_O, DONE, BUSY <= 0; FSM->IDLE.
//   Reset mid-computation aborts; no partial results retained.
//  Handshake: ACK_O <= CYC_I & STB_I & ~ACK_O; single-cycle pulse, one cycle after
//   request; low >=1 cycle between transfers. Write/read take effect on the ack cycle.
//  Address map (ADR_I): 0x00 CTRL W: bit0=1 -> START (self-clearing, reads 0)
//   0x08 STATUS R: bit0 DONE, bit1 BUSY, others 0
//   0x10+k X_real[k] RW | 0x20+k X_imag[k] RW | 0x30+n x_real[n] R | 0x38..0x3F,
//   0x40+n x_imag[n] R, k,n=0..7. Unmapped reads return 0; writes to R-only/unmapped ignored, still acked.
//  FSM: IDLE -(START)-> BUSY -(64th MAC done)-> DONE_ST -(START)-> BUSY.
//   START clears DONE, sets BUSY. START while BUSY ignored. X writes while BUSY ignored.
//  Compute: one complex MAC per cycle, n outer, k inner; twiddle index m=(k*n) mod 8,
//   W[m]=cos(2pi m/8)+j sin(2pi m/8) in Q1.14 (16384, 11585, 0, -11585, -16384).
//   acc_re += Xr*c - Xi*s; acc_im += Xr*s + Xi*c; 52-bit signed accumulators.
//   Result = acc >>> (TW_FRAC+3), low 32 bits (wrap, no saturation). DONE set <=70 cycles after START ack.
//  DONE sticky until next START or reset; outputs hold until overwritten by next run.
// CONFIGURATION
//  IDFT_ROUND_EN defined: add 2^(TW_FRAC+2) to acc before shift (round half up).
//  Undefined: plain arithmetic shift (floor). Both otherwise identical.
// STRUCTURE
//  Package idft8_pkg: register address constants, DATA_W/ACC width localparams,
//   twiddle cos/sin table (8 entries), FSM state typedef.
//  Sub-module idft8_core: MAC engine + twiddle lookup + output register file;
//   top holds Wishbone decode, input registers, CTRL/STATUS.
// TESTING
//  Reset then read 0x08 -> 0; read 0x30 -> 0; every access yields exactly one ACK_O pulse.
//  X_real[0]=8, all else 0, START, poll -> DONE=1, x_real[n]=1, x_imag[n]=0 for n=0..7.
//  X_real[k]=8 all k -> x_real[0]=8, x_real[1..7]=0, x_imag all 0.
//  X_real[1]=-800 -> x_real[0]=-100, x_real[2]=0, x_imag[2]=-100, x_real[4]=100;
//   x_real[1]=-71 (ROUND_EN) / -71 (floor); x_imag[1]=-71.
//  START while BUSY and X write while BUSY -> ignored, results unchanged; new START clears DONE.
//  Random X in +/-999 over 20 frames, RST_I pulse between frames -> match double-precision model
//   within +/-1 LSB.

Source files
------------

// File: rtl/idft8_pkg.sv
// Shared constants, twiddle table and FSM state for the idft8 Wishbone peripheral.
// Rounding option (IDFT_ROUND_EN) lives in idft8_core; nothing here depends on it.
package idft8_pkg;

    localparam int DW_DEF  = 32;
    localparam int TWF_DEF = 14;
    localparam int AW_DEF  = 8;

    localparam int TW_W    = 16;
    // 48-bit products, +1 for the complex add, +3 for eight terms
    localparam int ACC_GRD = 4;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h08;
    localparam logic [7:0] A_XR     = 8'h10;
    localparam logic [7:0] A_XI     = 8'h20;
    localparam logic [7:0] A_YR     = 8'h30;
    localparam logic [7:0] A_YI     = 8'h40;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // cos(2*pi*m/8) in Q1.14
    function automatic logic signed [TW_W-1:0] tw_cos(
        input logic [2:0] m
    );
        logic signed [TW_W-1:0] c;
        unique case (m)
            3'd0:    c = 16'sd16384;
            3'd1:    c = 16'sd11585;
            3'd2:    c = 16'sd0;
            3'd3:    c = -16'sd11585;
            3'd4:    c = -16'sd16384;
            3'd5:    c = -16'sd11585;
            3'd6:    c = 16'sd0;
            default: c = 16'sd11585;
        endcase
        return c;
    endfunction

    // sin(x) = cos(x - pi/2), i.e. two table steps back
    function automatic logic signed [TW_W-1:0] tw_sin(
        input logic [2:0] m
    );
        return tw_cos(3'(m - 3'd2));
    endfunction

endpackage

// File: rtl/idft8_core.sv
// 8-point IDFT engine: one complex MAC per cycle, n outer / k inner, result bank.
// IDFT_ROUND_EN adds half an LSB before the final shift; default is floor.
module idft8_core
    import idft8_pkg::*;
#(
    parameter int DATA_W  = DW_DEF,
    parameter int TW_FRAC = TWF_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*DATA_W-1:0] xr_in,
    input  logic [8*DATA_W-1:0] xi_in,
    output logic [8*DATA_W-1:0] yr_out,
    output logic [8*DATA_W-1:0] yi_out,
    output logic                busy,
    output logic                done
);

    localparam int ACC_W = DATA_W + TW_W + ACC_GRD;
    localparam int SHIFT = TW_FRAC + 3;

    state_t                   state;
    logic [2:0]               n;
    logic [2:0]               k;
    logic [2:0]               m;
    logic signed [TW_W-1:0]   c;
    logic signed [TW_W-1:0]   s;
    logic signed [DATA_W-1:0] xr_k;
    logic signed [DATA_W-1:0] xi_k;
    logic signed [ACC_W-1:0]  acc_re;
    logic signed [ACC_W-1:0]  acc_im;
    logic signed [ACC_W-1:0]  sum_re;
    logic signed [ACC_W-1:0]  sum_im;
    logic signed [ACC_W-1:0]  bias;
    logic [DATA_W-1:0]        res_re;
    logic [DATA_W-1:0]        res_im;

    assign m = 3'(k * n);

`ifdef IDFT_ROUND_EN
    assign bias = ACC_W'(1) << (SHIFT - 1);
`else
    assign bias = '0;
`endif

    // Operand and twiddle selection for the current (n, k) step
    always_comb begin
        c    = tw_cos(m);
        s    = tw_sin(m);
        xr_k = xr_in[k*DATA_W +: DATA_W];
        xi_k = xi_in[k*DATA_W +: DATA_W];
    end

    // Complex MAC and scaled result for the bin being closed
    always_comb begin
        sum_re = acc_re
               + ACC_W'(xr_k) * ACC_W'(c)
               - ACC_W'(xi_k) * ACC_W'(s);
        sum_im = acc_im
               + ACC_W'(xr_k) * ACC_W'(s)
               + ACC_W'(xi_k) * ACC_W'(c);
        res_re = DATA_W'((sum_re + bias) >>> SHIFT);
        res_im = DATA_W'((sum_im + bias) >>> SHIFT);
    end

    // Sequencer: 64 MAC steps per run, one result pair stored every 8th step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            n      <= '0;
            k      <= '0;
            acc_re <= '0;
            acc_im <= '0;
            yr_out <= '0;
            yi_out <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state  <= S_BUSY;
                        n      <= '0;
                        k      <= '0;
                        acc_re <= '0;
                        acc_im <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                S_BUSY: begin
                    k <= k + 3'd1;
                    if (k == 3'd7) begin
                        yr_out[n*DATA_W +: DATA_W] <= res_re;
                        yi_out[n*DATA_W +: DATA_W] <= res_im;
                        acc_re <= '0;
                        acc_im <= '0;
                        n      <= n + 3'd1;
                        if (n == 3'd7) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        acc_re <= sum_re;
                        acc_im <= sum_im;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/idft8_wb_top.sv
// Wishbone classic slave wrapper: bus decode, X input bank, CTRL/STATUS.
// Build option IDFT_ROUND_EN selects round-half-up results in idft8_core.
module idft8_wb_top
    import idft8_pkg::*;
#(
    parameter int DATA_W  = DW_DEF,
    parameter int TW_FRAC = TWF_DEF,
    parameter int ADR_W   = AW_DEF
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    input  logic [ADR_W-1:0]  ADR_I,
    input  logic [DATA_W-1:0] DAT_I,
    output logic [DATA_W-1:0] DAT_O,
    output logic              ACK_O
);

    logic                req;
    logic                wr_en;
    logic                rd_en;
    logic                hit_ctrl;
    logic                hit_stat;
    logic                hit_xr;
    logic                hit_xi;
    logic                hit_yr;
    logic                hit_yi;
    logic [2:0]          idx;
    logic                start;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   rd_data;
    logic [8*DATA_W-1:0] xr_q;
    logic [8*DATA_W-1:0] xi_q;
    logic [8*DATA_W-1:0] yr;
    logic [8*DATA_W-1:0] yi;

    assign req   = CYC_I & STB_I & ~ACK_O;
    assign wr_en = req & WE_I;
    assign rd_en = req & ~WE_I;
    assign idx   = ADR_I[2:0];

    assign hit_ctrl = ADR_I == ADR_W'(A_CTRL);
    assign hit_stat = ADR_I == ADR_W'(A_STATUS);
    assign hit_xr   = (ADR_I >> 3) == (ADR_W'(A_XR) >> 3);
    assign hit_xi   = (ADR_I >> 3) == (ADR_W'(A_XI) >> 3);
    assign hit_yr   = (ADR_I >> 3) == (ADR_W'(A_YR) >> 3);
    assign hit_yi   = (ADR_I >> 3) == (ADR_W'(A_YI) >> 3);

    assign start = wr_en & hit_ctrl & DAT_I[0];

    // Read-data mux; CTRL and unmapped addresses read as zero
    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            hit_stat: rd_data = DATA_W'({busy, done});
            hit_xr:   rd_data = xr_q[idx*DATA_W +: DATA_W];
            hit_xi:   rd_data = xi_q[idx*DATA_W +: DATA_W];
            hit_yr:   rd_data = yr[idx*DATA_W +: DATA_W];
            hit_yi:   rd_data = yi[idx*DATA_W +: DATA_W];
            default:  rd_data = '0;
        endcase
    end

    // Single-cycle ack with read data captured on the same edge
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            ACK_O <= 1'b0;
            DAT_O <= '0;
        end else begin
            ACK_O <= req;
            DAT_O <= rd_en ? rd_data : '0;
        end
    end

    // Input sample bank; frozen while the engine is running
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            xr_q <= '0;
            xi_q <= '0;
        end else if (wr_en && !busy) begin
            if (hit_xr) begin
                xr_q[idx*DATA_W +: DATA_W] <= DAT_I;
            end
            if (hit_xi) begin
                xi_q[idx*DATA_W +: DATA_W] <= DAT_I;
            end
        end
    end

    idft8_core #(
        .DATA_W  (DATA_W),
        .TW_FRAC (TW_FRAC)
    ) u_core (
        .clk    (CLK_I),
        .rst_n  (RST_I),
        .start  (start),
        .xr_in  (xr_q),
        .xi_in  (xi_q),
        .yr_out (yr),
        .yi_out (yi),
        .busy   (busy),
        .done   (done)
    );

endmodule

// File: tb/tb_idft8_wb_top.sv
// Bench for idft8_wb_top: directed frames with hand-worked results, then
// random frames against a floating-point IDFT; reads checked by a scoreboard.
`timescale 1ns/1ps
module tb_idft8_wb_top;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [7:0]  adr   = '0;
    logic [31:0] dati  = '0;
    logic [31:0] dato;
    logic        ack;

    always #5 clk = ~clk;

    idft8_wb_top dut (
        .CLK_I (clk),
        .RST_I (rst_n),
        .CYC_I (cyc),
        .STB_I (stb),
        .WE_I  (we),
        .ADR_I (adr),
        .DAT_I (dati),
        .DAT_O (dato),
        .ACK_O (ack)
    );

    typedef struct {
        bit         chk;
        logic [7:0] a;
        int         exp;
        int         tol;
    } sb_t;

    sb_t sbq[$];
    int  checks   = 0;
    int  failures = 0;
    bit  ack_prev = 1'b0;

`ifdef IDFT_ROUND_EN
    localparam int P71 = 71;
`else
    localparam int P71 = 70;
`endif
    localparam real R2 = 0.7071067811865476;

    // results for X_real[1] = -800, everything else zero
    int  c_re[8] = '{-100, -71, 0, P71, 100, P71, 0, -71};
    int  c_im[8] = '{0, -71, -100, -71, 0, P71, 100, P71};
    real cr[8]   = '{1.0, R2, 0.0, -R2, -1.0, -R2, 0.0, R2};

    // monitor: every ack is a lone pulse; every read ack pops the scoreboard
    always @(negedge clk) begin : mon
        sb_t e;
        int  diff;
        if (ack) begin
            checks++;
            if (ack_prev) begin
                failures++;
                $display("FAIL ack_pulse adr=%h ack=1 on consecutive cycles, required single pulse", adr);
            end
            if (!we) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty adr=%h read ack with no expected entry", adr);
                end else begin
                    e = sbq.pop_front();
                    if (e.chk) begin
                        checks++;
                        diff = int'($signed(dato)) - e.exp;
                        if (diff > e.tol || diff < -e.tol) begin
                            failures++;
                            $display("FAIL rd_%h got=%0d required=%0d tol=%0d",
                                     e.a, $signed(dato), e.exp, e.tol);
                        end
                    end
                end
            end
        end
        ack_prev = ack;
    end

    task automatic bus(input bit w, input int a, input int d, output logic [31:0] q);
        int n;
        @(posedge clk);
        #1;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = 8'(a);
        dati = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 16);
        if (!ack) begin
            $display("FAIL bus_timeout adr=%h no ack in 16 cycles, required ack", adr);
            $fatal(1, "bus timeout");
        end
        q = dato;
        @(posedge clk);
        #1;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        logic [31:0] q;
        bus(1'b1, a, d, q);
    endtask

    task automatic rd_chk(input int a, input int e, input int tol);
        logic [31:0] q;
        sb_t s;
        s.chk = 1'b1;
        s.a   = 8'(a);
        s.exp = e;
        s.tol = tol;
        sbq.push_back(s);
        bus(1'b0, a, 0, q);
    endtask

    task automatic rd_raw(input int a, output logic [31:0] q);
        sb_t s;
        s.chk = 1'b0;
        s.a   = 8'(a);
        s.exp = 0;
        s.tol = 0;
        sbq.push_back(s);
        bus(1'b0, a, 0, q);
    endtask

    task automatic wait_done();
        logic [31:0] q;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            rd_raw(8'h08, q);
            ok = q[0];
        end
        if (!ok) begin
            $display("FAIL done_timeout DONE=0 after 100 polls, required 1");
            $fatal(1, "done timeout");
        end
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    initial begin : drv
        int  xr[8];
        int  xi[8];
        real re;
        real im;
        int  m;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        rd_chk(8'h08, 0, 0);
        rd_chk(8'h30, 0, 0);
        rd_chk(8'h44, 0, 0);

        // impulse at k=0 -> flat 1
        wr(8'h10, 8);
        rd_chk(8'h10, 8, 0);
        wr(8'h00, 1);
        rd_chk(8'h08, 2, 0);
        wait_done();
        rd_chk(8'h08, 1, 0);
        rd_chk(8'h00, 0, 0);
        for (int n = 0; n < 8; n++) begin
            rd_chk(8'h30 + n, 1, 0);
            rd_chk(8'h40 + n, 0, 0);
        end
        rd_chk(8'h38, 0, 0);
        rd_chk(8'h50, 0, 0);

        // constant 8 -> impulse of 8 at n=0
        for (int k = 0; k < 8; k++) wr(8'h10 + k, 8);
        wr(8'h00, 1);
        wait_done();
        for (int n = 0; n < 8; n++) begin
            rd_chk(8'h30 + n, (n == 0) ? 8 : 0, 0);
            rd_chk(8'h40 + n, 0, 0);
        end

        // single tone at k=1
        for (int k = 0; k < 8; k++) wr(8'h10 + k, (k == 1) ? -800 : 0);
        wr(8'h00, 1);
        wait_done();
        for (int n = 0; n < 8; n++) begin
            rd_chk(8'h30 + n, c_re[n], 0);
            rd_chk(8'h40 + n, c_im[n], 0);
        end

        // writes to result registers are ignored
        wr(8'h30, 1234);
        rd_chk(8'h30, -100, 0);

        // new START clears DONE; START and X writes while busy ignored
        wr(8'h00, 1);
        rd_chk(8'h08, 2, 0);
        wr(8'h00, 1);
        wr(8'h11, 5);
        wr(8'h20, 77);
        rd_chk(8'h11, -800, 0);
        rd_chk(8'h20, 0, 0);
        wait_done();
        rd_chk(8'h08, 1, 0);
        rd_chk(8'h08, 1, 0);
        for (int n = 0; n < 8; n++) begin
            rd_chk(8'h30 + n, c_re[n], 0);
            rd_chk(8'h40 + n, c_im[n], 0);
        end

        // reset during a run discards everything
        wr(8'h00, 1);
        repeat (10) @(posedge clk);
        rst_pulse();
        rd_chk(8'h08, 0, 0);
        rd_chk(8'h11, 0, 0);
        rd_chk(8'h30, 0, 0);
        rd_chk(8'h42, 0, 0);

        // random frames against a double-precision IDFT
        for (int f = 0; f < 20; f++) begin
            rst_pulse();
            for (int k = 0; k < 8; k++) begin
                xr[k] = int'($urandom_range(1998)) - 999;
                xi[k] = int'($urandom_range(1998)) - 999;
                wr(8'h10 + k, xr[k]);
                wr(8'h20 + k, xi[k]);
            end
            wr(8'h00, 1);
            wait_done();
            for (int n = 0; n < 8; n++) begin
                re = 0.0;
                im = 0.0;
                for (int k = 0; k < 8; k++) begin
                    m  = (k * n) % 8;
                    re = re + xr[k] * cr[m] - xi[k] * cr[(m + 6) % 8];
                    im = im + xr[k] * cr[(m + 6) % 8] + xi[k] * cr[m];
                end
                rd_chk(8'h30 + n, rnd(re / 8.0), 1);
                rd_chk(8'h40 + n, rnd(im / 8.0), 1);
            end
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
